// File: rtl/mio_bus_n_pkg.sv
// Shared definitions for the mio_bus_n memory-mapped I/O bus.
//  - state_e       : bus FSM states
//  - ERR_RDATA     : read data returned on an error response
//  - DEF_SLOT_BASE : default 4-slot base map {F,E,C,0} (slot i in field i)
//  - DEF_SLOT_WAIT : default 4-slot wait states {0,0,1,2}
//  - idx_w()       : slot-index width, never below one bit
package mio_bus_n_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic [63:0] ERR_RDATA     = 64'h0;
  localparam logic [15:0] DEF_SLOT_BASE = {4'hF, 4'hE, 4'hC, 4'h0};
  localparam logic [15:0] DEF_SLOT_WAIT = {4'd0, 4'd0, 4'd1, 4'd2};

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mio_bus_n_if.sv
// Bus bundle between the CPU data port, the I/O bus and the peripheral slots.
//  slave  : view taken by mio_bus_n (receives CPU requests, drives slots)
//  master : view taken by the environment (CPU + slot models)
// Signals: cpu_req/we/addr/wdata -> bus; cpu_rdata/ready/err <- bus;
//          slv_sel/we/addr/wdata <- bus; slv_rdata/ack -> bus.
interface mio_bus_n_if #(
  parameter int unsigned N_SLOT = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 32
) ();
  logic                 cpu_req;
  logic                 cpu_we;
  logic [AW-1:0]        cpu_addr;
  logic [DW-1:0]        cpu_wdata;
  logic [DW-1:0]        cpu_rdata;
  logic                 cpu_ready;
  logic                 cpu_err;
  logic [N_SLOT-1:0]    slv_sel;
  logic                 slv_we;
  logic [AW-1:0]        slv_addr;
  logic [DW-1:0]        slv_wdata;
  logic [N_SLOT*DW-1:0] slv_rdata;
  logic [N_SLOT-1:0]    slv_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_err,
    output slv_sel, slv_we, slv_addr, slv_wdata,
    input  slv_rdata, slv_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_err,
    input  slv_sel, slv_we, slv_addr, slv_wdata,
    output slv_rdata, slv_ack
  );
endinterface

// File: rtl/mio_bus_n_slot_decode.sv
// Combinational priority decoder: address select field -> {hit, slot index, one-hot}.
// Ports: field (addr[AW-1:SEL_LO]) in; hit, idx, onehot out. Lowest matching slot wins.
module mio_bus_n_slot_decode
  import mio_bus_n_pkg::*;
#(
  parameter int unsigned          N_SLOT    = 4,
  parameter int unsigned          FW        = 4,
  parameter int unsigned          IW        = idx_w(N_SLOT),
  parameter logic [N_SLOT*FW-1:0] SLOT_BASE = DEF_SLOT_BASE
) (
  input  logic [FW-1:0]     field,
  output logic              hit,
  output logic [IW-1:0]     idx,
  output logic [N_SLOT-1:0] onehot
);

  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    onehot = '0;
    // Scan downward so the lowest matching slot is the last writer.
    for (int i = N_SLOT - 1; i >= 0; i--) begin
      if (field == SLOT_BASE[i*FW +: FW]) begin
        hit       = 1'b1;
        idx       = IW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mio_bus_n.sv
// Memory-mapped I/O bus: CPU data port -> N_SLOT peripheral slots.
// Decodes addr[AW-1:SEL_LO] to a slot, applies that slot's wait states, runs the
// select/ack handshake and returns registered read data with a ready/err pulse.
// Ports: clk, rst (async, active-high), bus (mio_bus_n_if.slave).
// Optional macro MIO_TIMEOUT_EN: abort an access with cpu_err after TIMEOUT cycles
// in ACCESS without a qualifying ack. Undefined: ACCESS waits indefinitely.
module mio_bus_n
  import mio_bus_n_pkg::*;
#(
  parameter int unsigned                      N_SLOT    = 4,
  parameter int unsigned                      DW        = 32,
  parameter int unsigned                      AW        = 32,
  parameter int unsigned                      SEL_LO    = 28,
  parameter logic [N_SLOT*(AW-SEL_LO)-1:0]    SLOT_BASE = DEF_SLOT_BASE,
  parameter int unsigned                      WAIT_W    = 4,
  parameter logic [N_SLOT*WAIT_W-1:0]         SLOT_WAIT = DEF_SLOT_WAIT,
  parameter int unsigned                      TIMEOUT   = 64
) (
  input logic         clk,
  input logic         rst,
  mio_bus_n_if.slave  bus
);

  localparam int unsigned FW = AW - SEL_LO;
  localparam int unsigned IW = idx_w(N_SLOT);

  if (N_SLOT < 1 || N_SLOT > 16 || TIMEOUT < 1) begin : g_param_check
    $error("mio_bus_n: N_SLOT must be 1..16 and TIMEOUT at least 1");
  end

  logic              dec_hit;
  logic [IW-1:0]     dec_idx;
  logic [N_SLOT-1:0] dec_onehot;

  mio_bus_n_slot_decode #(
    .N_SLOT    (N_SLOT),
    .FW        (FW),
    .IW        (IW),
    .SLOT_BASE (SLOT_BASE)
  ) u_decode (
    .field  (bus.cpu_addr[AW-1:SEL_LO]),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  state_e            state_q;
  logic [IW-1:0]     slot_q;
  logic [WAIT_W-1:0] wait_q;
  logic [DW-1:0]     rdata_q;
  logic              ready_q;
  logic              err_q;
  logic [N_SLOT-1:0] sel_q;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;

`ifdef MIO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
`endif

  // Only the latched slot's ack counts, and only once its wait states have elapsed.
  logic          ack_ok;
  logic [DW-1:0] rdata_sel;
  assign ack_ok    = (wait_q == '0) && bus.slv_ack[slot_q];
  assign rdata_sel = bus.slv_rdata[slot_q*DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      slot_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MIO_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            slot_q  <= dec_idx;
            if (dec_hit) begin
              state_q <= StAccess;
              sel_q   <= dec_onehot;
              we_q    <= bus.cpu_we;
              wait_q  <= SLOT_WAIT[dec_idx*WAIT_W +: WAIT_W];
`ifdef MIO_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end else begin
              // Decode miss: answer straight away, never touch a slot.
              state_q <= StResp;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= ERR_RDATA[DW-1:0];
            end
          end
        end
        StAccess: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - 1'b1;
          end
          if (ack_ok) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            rdata_q <= we_q ? '0 : rdata_sel;
            sel_q   <= '0;
            we_q    <= 1'b0;
`ifdef MIO_TIMEOUT_EN
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= ERR_RDATA[DW-1:0];
            sel_q   <= '0;
            we_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_err   = err_q;
  assign bus.slv_sel   = sel_q;
  assign bus.slv_we    = we_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;

endmodule
